// File: rtl/nd_tile_packer_if.sv
// rtl/nd_tile_packer_if.sv - element-in / tile-out handshake bundle for nd_tile_packer
interface nd_tile_packer_if #(
  parameter int ROWS  = 3,
  parameter int COLS  = 4,
  parameter int WIDTH = 6
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [WIDTH-1:0]                      in_data;
  logic                                  in_last;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]  out_tile;
  logic                                  err;

  // Packer side: consumes elements, produces tiles.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_tile, err
  );

  // Driver side: produces elements, consumes tiles.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_tile, err
  );
endinterface

// File: rtl/nd_tile_packer.sv
// rtl/nd_tile_packer.sv - packs a WIDTH-bit element stream into ROWSxCOLS tiles; TILE_PACKER_DBUF_EN selects ping-pong banks
module nd_tile_packer #(
  parameter int ROWS  = 3,
  parameter int COLS  = 4,
  parameter int WIDTH = 6
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  nd_tile_packer_if.slave  io
);
  localparam int N  = ROWS * COLS;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = N * WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic            err_q;
  logic            in_ready_q;
  logic            out_valid_q;

  logic            acc;
  logic            last_slot;
  logic            complete;
  logic            handoff;
  logic [TW-1:0]   cur_wr;
  logic [TW-1:0]   fill_d;
  logic [TW-1:0]   rd_tile;
  logic            out_valid_d;
  logic            wr_full_d;
  logic            all_full_d;

  // Handshake events for this cycle.
  always_comb begin
    acc       = io.in_valid && in_ready_q;
    last_slot = (k_q == KW'(N - 1));
    complete  = acc && (io.in_last || last_slot);
    handoff   = out_valid_q && io.out_ready;
  end

  // Next content of the write bank: cleared on the first element of a tile, slot k takes in_data.
  always_comb begin
    fill_d = (state_q == IDLE) ? '0 : cur_wr;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) fill_d[i*WIDTH +: WIDTH] = io.in_data;
    end
  end

`ifdef TILE_PACKER_DBUF_EN
  logic [TW-1:0] bank0_q;
  logic [TW-1:0] bank1_q;
  logic [1:0]    full_q;
  logic [1:0]    full_d;
  logic          wr_q;
  logic          rd_q;
  logic          wr_d;
  logic          rd_d;

  // Ping-pong occupancy: handoff frees the read bank, completion fills the write bank.
  always_comb begin
    full_d = full_q;
    if (handoff)  full_d[rd_q] = 1'b0;
    if (complete) full_d[wr_q] = 1'b1;
    wr_d        = wr_q ^ complete;
    rd_d        = rd_q ^ handoff;
    out_valid_d = full_d[rd_d];
    wr_full_d   = full_d[wr_d];
    all_full_d  = &full_d;
    cur_wr      = wr_q ? bank1_q : bank0_q;
    rd_tile     = rd_q ? bank1_q : bank0_q;
  end

  // Bank storage and pointers.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      bank0_q <= '0;
      bank1_q <= '0;
      full_q  <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      full_q <= full_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      if (acc) begin
        if (wr_q) bank1_q <= fill_d;
        else      bank0_q <= fill_d;
      end
    end
  end
`else
  logic [TW-1:0] bank_q;
  logic          full_q;
  logic          full_d;

  // Single bank: accepts are blocked while full, so completion and handoff never coincide.
  always_comb begin
    full_d      = (full_q && !handoff) || complete;
    out_valid_d = full_d;
    wr_full_d   = full_d;
    all_full_d  = full_d;
    cur_wr      = bank_q;
    rd_tile     = bank_q;
  end

  // Bank storage.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      bank_q <= '0;
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (acc) bank_q <= fill_d;
    end
  end
`endif

  // Fill FSM with registered handshake outputs, fill index and sticky framing error.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q     <= IDLE;
      k_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= !all_full_d;
      out_valid_q <= out_valid_d;
      if (acc && last_slot && !io.in_last) err_q <= 1'b1;
      if (complete)  k_q <= '0;
      else if (acc)  k_q <= k_q + KW'(1);
      case (state_q)
        IDLE: begin
          if (complete)  state_q <= wr_full_d ? DONE : IDLE;
          else if (acc)  state_q <= FILL;
        end
        FILL: begin
          if (complete)  state_q <= wr_full_d ? DONE : IDLE;
        end
        DONE: begin
          if (!wr_full_d) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_tile  = out_valid_q ? rd_tile : '0;
  assign io.err       = err_q;
endmodule

// File: tb/tb_nd_tile_packer.sv
// tb/tb_nd_tile_packer.sv - randomized and directed bench for nd_tile_packer with a queue-based tile model
module tb_nd_tile_packer;
  localparam int ROWS  = 3;
  localparam int COLS  = 4;
  localparam int WIDTH = 6;
  localparam int N     = ROWS * COLS;
`ifdef TILE_PACKER_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] tile_t;

  logic CLK = 1'b0;
  logic ASYNCRESETN = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  nd_tile_packer_if #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) bus ();

  nd_tile_packer #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .io          (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: list of completed tiles awaiting handoff, plus the tile being filled.
  tile_t m_q[$];
  tile_t m_cur;
  int    m_cnt = 0;
  bit    m_err = 1'b0;

  always @(negedge CLK) begin
    if (!ASYNCRESETN) begin
      m_q.delete();
      m_cnt = 0;
      m_err = 1'b0;
      m_cur = '0;
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_err", bus.err, 1'b0);
      chk("rst_out_tile", bus.out_tile, '0);
    end else begin
      bit acc;
      bit hand;
      chk("in_ready", bus.in_ready, m_q.size() < NB);
      chk("out_valid", bus.out_valid, m_q.size() > 0);
      chk("err", bus.err, m_err);
      if (m_q.size() > 0) chk("out_tile", bus.out_tile, m_q[0]);
      acc  = bus.in_valid && (m_q.size() < NB);
      hand = (m_q.size() > 0) && bus.out_ready;
      if (hand) void'(m_q.pop_front());
      if (acc) begin
        if (m_cnt == 0) m_cur = '0;
        m_cur[m_cnt / COLS][m_cnt % COLS] = bus.in_data;
        m_cnt++;
        if (bus.in_last || m_cnt == N) begin
          if (!bus.in_last) m_err = 1'b1;
          m_q.push_back(m_cur);
          m_cnt = 0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int   g;
    logic ok;
    g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    do begin
      @(negedge CLK);
      ok = bus.in_ready;
      cyc();
      g++;
    end while (!ok && g < 100);
    chk("send_accept", ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tile_t exp_t;
    tile_t held;
    bit    have;
    int    acc_n;
    int    cycles;
    logic [WIDTH-1:0] v [N];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) cyc();
    chk("lit_rst_ready", bus.in_ready, 1'b1);
    chk("lit_rst_tile", bus.out_tile, '0);
    ASYNCRESETN = 1'b1;
    bus.out_ready = 1'b1;
    cyc();

    // Full tile 0..11, in_last on the 12th.
    for (int i = 0; i < N; i++) send(WIDTH'(i), i == N - 1);
    bus.in_valid = 1'b0;
    chk("lit_full_valid", bus.out_valid, 1'b1);
    chk("lit_full_t11", bus.out_tile[1][1], 6'd5);
    chk("lit_full_t23", bus.out_tile[2][3], 6'd11);
    chk("lit_full_err", bus.err, 1'b0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_t[r][c] = WIDTH'(4 * r + c);
    chk("lit_full_tile", bus.out_tile, exp_t);
    repeat (2) cyc();

    // Early in_last on the 5th element.
    for (int i = 1; i <= 5; i++) send(WIDTH'(i), i == 5);
    bus.in_valid = 1'b0;
    exp_t = '0;
    for (int i = 0; i < 4; i++) exp_t[0][i] = WIDTH'(i + 1);
    exp_t[1][0] = 6'd5;
    chk("lit_early_tile", bus.out_tile, exp_t);
    repeat (2) cyc();
    send(6'd7, 1'b1);
    bus.in_valid = 1'b0;
    chk("lit_next_t00", bus.out_tile[0][0], 6'd7);
    chk("lit_next_t01", bus.out_tile[0][1], 6'd0);
    repeat (2) cyc();

    // Missing in_last: err sets and stays set.
    for (int i = 0; i < N; i++) send(WIDTH'(i + 20), 1'b0);
    bus.in_valid = 1'b0;
    chk("lit_nolast_valid", bus.out_valid, 1'b1);
    chk("lit_nolast_err", bus.err, 1'b1);
    repeat (2) cyc();
    for (int i = 0; i < N; i++) send(WIDTH'(i), i == N - 1);
    bus.in_valid = 1'b0;
    repeat (2) cyc();
    chk("lit_err_sticky", bus.err, 1'b1);
    #2 ASYNCRESETN = 1'b0;
    #1 chk("lit_err_cleared", bus.err, 1'b0);
    cyc();
    ASYNCRESETN = 1'b1;
    cyc();

    // Output stall: occupancy limits accepts, head tile holds still.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    acc_n = 0;
    have  = 1'b0;
    held  = '0;
    for (int c = 0; c < 30; c++) begin
      bus.in_data = WIDTH'(acc_n);
      bus.in_last = (acc_n % N) == N - 1;
      @(negedge CLK);
      if (bus.in_ready) acc_n++;
      if (bus.out_valid) begin
        if (!have) begin
          held = bus.out_tile;
          have = 1'b1;
        end else begin
          chk("stall_stable", bus.out_tile, held);
        end
      end
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("stall_accepts", acc_n, N * NB);
    chk("stall_ready_low", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    repeat (6) cyc();

    // Continuous stream of three tiles.
    acc_n  = 0;
    cycles = 0;
    bus.in_valid = 1'b1;
    while (acc_n < 3 * N && cycles < 100) begin
      bus.in_data = WIDTH'(acc_n);
      bus.in_last = (acc_n % N) == N - 1;
      @(negedge CLK);
      if (bus.in_ready) acc_n++;
      cyc();
      cycles++;
    end
    bus.in_valid = 1'b0;
    chk("stream_cycles", cycles, (NB == 2) ? 3 * N : 3 * N + 2);
    repeat (4) cyc();

    // Reset mid-fill with a held tile (held only when a second bank exists).
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(WIDTH'(i + 40), i == N - 1);
    bus.in_valid = 1'b0;
    if (NB == 1) begin
      bus.out_ready = 1'b1;
      repeat (2) cyc();
    end
    for (int i = 0; i < 7; i++) send(WIDTH'(i + 50), 1'b0);
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", bus.out_valid, NB == 2);
    #2 ASYNCRESETN = 1'b0;
    #1;
    chk("lit_midrst_valid", bus.out_valid, 1'b0);
    chk("lit_midrst_tile", bus.out_tile, '0);
    chk("lit_midrst_ready", bus.in_ready, 1'b1);
    cyc();
    ASYNCRESETN = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    for (int i = 0; i < N; i++) v[i] = WIDTH'($urandom);
    for (int i = 0; i < N; i++) send(v[i], i == N - 1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < N; i++) exp_t[i / COLS][i % COLS] = v[i];
    chk("lit_clean_tile", bus.out_tile, exp_t);
    chk("lit_clean_err", bus.err, 1'b0);
    repeat (2) cyc();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.in_data   = WIDTH'($urandom);
      bus.in_last   = $urandom_range(0, 9) == 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
